// File: rtl/pipe_adder_pkg.sv
// Shared defaults and slice-width helper for the pipelined adder.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result stream bundle for pipe_adder; slave is the adder side.
// Carries the ovf flag only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if #(
  parameter int WIDTH = pipe_adder_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef PIPE_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, s, cout
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef PIPE_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, s, cout
  );

endinterface

// File: rtl/adder_slice.sv
// Combinational W-bit slice adder with carry in/out; one per pipeline stage.
module adder_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add split into STAGES registered slices, valid/ready with global stall.
// Optional macro PIPE_ADDER_OVF_EN adds a registered two's-complement overflow output.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  logic adv_s;
  logic out_valid_s;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  // acc holds the finished sum slices below LO and the still-unadded A slices above;
  // the unadded B slices travel in a narrower register that shrinks every stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic [WIDTH-1:0] acc_in_s;
    logic [REM-1:0]   b_in_s;
    logic             c_in_s;
    logic             v_in_s;
    logic [CHUNK-1:0] sum_s;
    logic [WIDTH-1:0] acc_d;
    logic             c_d;
    logic [WIDTH-1:0] acc_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign acc_in_s = bus.a;
      assign b_in_s   = bus.b;
      assign c_in_s   = bus.cin;
      assign v_in_s   = bus.in_valid;
    end else begin : g_link
      assign acc_in_s = g_stg[k-1].acc_q;
      assign b_in_s   = g_stg[k-1].g_fwd.b_q;
      assign c_in_s   = g_stg[k-1].c_q;
      assign v_in_s   = g_stg[k-1].v_q;
    end

    adder_slice #(.W(CHUNK)) u_slice (
      .a    (acc_in_s[LO +: CHUNK]),
      .b    (b_in_s[CHUNK-1:0]),
      .cin  (c_in_s),
      .s    (sum_s),
      .cout (c_d)
    );

    always_comb begin
      acc_d              = acc_in_s;
      acc_d[LO +: CHUNK] = sum_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (adv_s) begin
        acc_q <= acc_d;
        c_q   <= c_d;
        v_q   <= v_in_s;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-CHUNK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q <= '0;
        end else if (adv_s) begin
          b_q <= b_in_s[REM-1:CHUNK];
        end
      end
    end

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (acc_in_s[WIDTH-1] == b_in_s[REM-1]) &&
                     (sum_s[CHUNK-1] != acc_in_s[WIDTH-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv_s) begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign out_valid_s   = g_stg[STAGES-1].v_q;
  assign adv_s         = bus.out_ready || !out_valid_s;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_s;
  assign bus.s         = g_stg[STAGES-1].acc_q;
  assign bus.cout      = g_stg[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
  assign bus.ovf       = g_stg[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: slot-based latency model plus in-order scoreboard.
module tb_pipe_adder;

`ifdef PIPE_ADDER_OVF_EN
  localparam int W  = 16;
  localparam int ST = 2;
`else
  localparam int W  = 64;
  localparam int ST = 4;
`endif

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
  } beat_t;

  typedef struct packed {
    logic         v;
    logic         o;
    logic         c;
    logic [W-1:0] s;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;

  pipe_adder_if #(.WIDTH(W)) bus ();

  pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    n_run  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  int    n_in   = 0;
  int    n_out  = 0;
  int    acc_cyc = -1;
  int    ov_cyc  = -1;
  beat_t pend[$];
  res_t  sb[$];
  res_t  slot_m[ST];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] a64, input logic [63:0] b64, input logic c);
    beat_t x;
    x.a = a64[W-1:0];
    x.b = b64[W-1:0];
    x.c = c;
    return x;
  endfunction

  function automatic beat_t rnd_beat();
    logic [63:0] ra;
    logic [63:0] rb;
    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    return mk(ra, rb, 1'($urandom_range(0, 1)));
  endfunction

  // Reference: plain wide addition; signed overflow from operand and result signs.
  function automatic res_t ref_add(input beat_t x);
    logic [W:0] full;
    res_t       r;
    full = {1'b0, x.a} + {1'b0, x.b} + {{W{1'b0}}, x.c};
    r.v  = 1'b1;
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.o  = (x.a[W-1] == x.b[W-1]) && (r.s[W-1] != x.a[W-1]);
    return r;
  endfunction

  // One clock: drive at negedge, check, then advance the slot model on the posedge.
  task automatic cycle(input logic ordy);
    beat_t x;
    logic  iv;
    logic  exp_rdy;
    res_t  got;
    iv = (pend.size() > 0);
    x  = iv ? pend[0] : '0;
    bus.in_valid  = iv;
    bus.a         = x.a;
    bus.b         = x.b;
    bus.cin       = x.c;
    bus.out_ready = ordy;
    #1;
    exp_rdy = ordy || !slot_m[ST-1].v;
    chk1("in_ready", bus.in_ready, exp_rdy);
    chk1("out_valid", bus.out_valid, slot_m[ST-1].v);
    if (slot_m[ST-1].v) begin
      chkw("s", bus.s, slot_m[ST-1].s);
      chk1("cout", bus.cout, slot_m[ST-1].c);
`ifdef PIPE_ADDER_OVF_EN
      chk1("ovf", bus.ovf, slot_m[ST-1].o);
`endif
    end
    if (bus.out_valid && ordy) begin
      n_out++;
      chk1("sb_nonempty", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        chkw("sb_s", bus.s, got.s);
        chk1("sb_cout", bus.cout, got.c);
      end
    end
    if (bus.out_valid && (ov_cyc < 0)) ov_cyc = cyc;
    @(posedge clk);
    if (exp_rdy) begin
      for (int i = ST - 1; i > 0; i--) slot_m[i] = slot_m[i-1];
      slot_m[0] = iv ? ref_add(x) : '0;
      if (iv) begin
        sb.push_back(ref_add(x));
        void'(pend.pop_front());
        n_in++;
        acc_cyc = cyc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < ST; i++) slot_m[i] = '0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chkw("rst_s", bus.s, '0);
    chk1("rst_cout", bus.cout, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
`ifdef PIPE_ADDER_OVF_EN
    chk1("rst_ovf", bus.ovf, 1'b0);
`endif
    rst_n = 1'b1;

    // Single zero beat: latency must equal the stage count.
    ov_cyc = -1;
    pend.push_back(mk(64'h0, 64'h0, 1'b0));
    for (int i = 0; i < ST + 3; i++) cycle(1'b1);
    chki("latency", ov_cyc - acc_cyc, ST);

    // Carry ripple across every slice boundary.
    pend.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1));
    pend.push_back(mk(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0));
    for (int i = 0; i < ST + 4; i++) cycle(1'b1);

    // Seven back-to-back beats.
    pend.push_back(mk(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0));
    for (int i = 0; i < 6; i++) pend.push_back(rnd_beat());
    for (int i = 0; i < 7 + ST + 1; i++) cycle(1'b1);

    // Six beats with a five-cycle downstream stall mid-stream.
    for (int i = 0; i < 6; i++) pend.push_back(rnd_beat());
    for (int i = 0; i < 3; i++) cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    for (int i = 0; i < 6 + ST + 2; i++) cycle(1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 60; i++) begin
      if ((pend.size() < 2) && ($urandom_range(0, 3) != 0)) pend.push_back(rnd_beat());
      cycle(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8 + ST; i++) cycle(1'b1);

    // Asynchronous reset with beats in flight.
    for (int i = 0; i < 3; i++) pend.push_back(rnd_beat());
    for (int i = 0; i < 3; i++) cycle(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chkw("midrst_s", bus.s, '0);
    chk1("midrst_cout", bus.cout, 1'b0);
    chk1("midrst_in_ready", bus.in_ready, 1'b1);
    n_in = n_in - sb.size();
    sb.delete();
    pend.delete();
    for (int i = 0; i < ST; i++) slot_m[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < ST + 4; i++) cycle(1'b1);

    // Signed-overflow boundary vectors.
    pend.push_back(mk(64'h7FFF, 64'h1, 1'b0));
    pend.push_back(mk(64'hFFFF, 64'h1, 1'b0));
    pend.push_back(mk(64'h8000, 64'h8000, 1'b0));
    for (int i = 0; i < 3 + ST + 2; i++) cycle(1'b1);

    chki("sb_left", sb.size(), 0);
    chki("beats_in_out", n_out, n_in);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
